poly_wave_generator: RTL and testbench



---
 rtl/synth_pkg.sv | 20 ++
 rtl/voice_shaper.sv | 44 ++++
 rtl/poly_wave_generator.sv | 139 +++++++++++++
 tb/tb_poly_wave_generator.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the polyphonic oscillator bank.
package synth_pkg;

   typedef enum logic [1:0] {
      SQUARE   = 2'd0,
      SAW      = 2'd1,
      TRIANGLE = 2'd2,
      SILENT   = 2'd3
   } wave_t;

   typedef enum logic {
      IDLE = 1'b0,
      MIX  = 1'b1
   } mix_state_t;

   localparam int WAVE_W = 16;
   localparam logic signed [WAVE_W-1:0] WAVE_MAX = 16'sh7FFF;
   localparam logic signed [WAVE_W-1:0] WAVE_MIN = 16'sh8000;

endpackage

// File: rtl/voice_shaper.sv
// Combinational waveform derivation and volume scaling for the voice selected by the mixer.
module voice_shaper
   import synth_pkg::*;
#(
   parameter int PHASE_W = 24,
   parameter int VOL_W   = 7
) (
   input  logic [PHASE_W-1:0]              phase,
   input  wave_t                           wave,
   input  logic                            gate,
   input  logic [VOL_W-1:0]                volume,
   output logic signed [WAVE_W+VOL_W-1:0]  term
);

   localparam int TERM_W = WAVE_W + VOL_W;

   logic [WAVE_W-1:0]         p;
   logic [WAVE_W-2:0]         tri_t;
   logic signed [WAVE_W-1:0]  wave_val;
   logic signed [TERM_W-1:0]  wave_ext;
   logic signed [TERM_W-1:0]  vol_ext;

   assign p     = phase[PHASE_W-1 -: WAVE_W];
   assign tri_t = p[WAVE_W-1] ? ~p[WAVE_W-2:0] : p[WAVE_W-2:0];

   // Subtracting 32768 from a 16-bit unsigned value is just an MSB flip.
   always_comb begin
      wave_val = '0;
      case (wave)
         SQUARE:   wave_val = p[WAVE_W-1] ? WAVE_MIN : WAVE_MAX;
         SAW:      wave_val = {~p[WAVE_W-1], p[WAVE_W-2:0]};
         TRIANGLE: wave_val = {~tri_t[WAVE_W-2], tri_t[WAVE_W-3:0], 1'b0};
         default:  wave_val = '0;
      endcase
      if (!gate) begin
         wave_val = '0;
      end
   end

   assign wave_ext = TERM_W'(wave_val);
   assign vol_ext  = $signed(TERM_W'(volume));
   assign term     = wave_ext * vol_ext;

endmodule

// File: rtl/poly_wave_generator.sv
// Multi-voice oscillator bank: per-voice config/phase registers and a serial mixer that
// evaluates one voice per clock after each sample tick, then saturates the sum.
module poly_wave_generator
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = 24,
   parameter int VOL_W      = 7,
   parameter int OUT_W      = 24,
   localparam int IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     sample_tick,
   input  logic                     cfg_valid,
   input  logic [IDX_W-1:0]         cfg_voice,
   input  logic [PHASE_W-1:0]       cfg_incr,
   input  logic [VOL_W-1:0]         cfg_volume,
   input  logic [1:0]               cfg_wave,
   input  logic                     cfg_gate,
   input  logic                     ovr_clr,
   output logic signed [OUT_W-1:0]  sample_out,
   output logic                     sample_valid,
   output logic                     overrun
);

   localparam int TERM_W = WAVE_W + VOL_W;
   localparam int ACC_W  = TERM_W + $clog2(NUM_VOICES);
   localparam int SAT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
   localparam logic signed [SAT_W-1:0] OUT_MAX = {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SAT_W-1:0] OUT_MIN = ~OUT_MAX;

   logic [PHASE_W-1:0]       incr   [NUM_VOICES];
   logic [PHASE_W-1:0]       phase  [NUM_VOICES];
   logic [VOL_W-1:0]         volume [NUM_VOICES];
   wave_t                    wave   [NUM_VOICES];
   logic                     gate   [NUM_VOICES];

   mix_state_t               state;
   logic [IDX_W-1:0]         idx;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  sum;
   logic signed [TERM_W-1:0] term;
   logic signed [SAT_W-1:0]  sum_wide;
   logic signed [OUT_W-1:0]  sat_val;
   logic                     cfg_hit;

   assign cfg_hit = cfg_valid && (int'(cfg_voice) < NUM_VOICES);

   voice_shaper #(
      .PHASE_W (PHASE_W),
      .VOL_W   (VOL_W)
   ) u_shaper (
      .phase  (phase[idx]),
      .wave   (wave[idx]),
      .gate   (gate[idx]),
      .volume (volume[idx]),
      .term   (term)
   );

   assign sum      = acc + ACC_W'(term);
   assign sum_wide = SAT_W'(sum);

   always_comb begin
      sat_val = OUT_W'(sum_wide);
      if (sum_wide > OUT_MAX) begin
         sat_val = OUT_W'(OUT_MAX);
      end else if (sum_wide < OUT_MIN) begin
         sat_val = OUT_W'(OUT_MIN);
      end
   end

   // The mixer reads registered values, so a write landing on a voice's own MIX slot
   // only affects the next sample; a gate rising edge overrides the slot's phase step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            incr[v]   <= '0;
            phase[v]  <= '0;
            volume[v] <= '0;
            wave[v]   <= SQUARE;
            gate[v]   <= 1'b0;
         end
      end else begin
         if (state == MIX) begin
            phase[idx] <= gate[idx] ? phase[idx] + incr[idx] : '0;
         end
         if (cfg_hit) begin
            incr[cfg_voice]   <= cfg_incr;
            volume[cfg_voice] <= cfg_volume;
            wave[cfg_voice]   <= wave_t'(cfg_wave);
            gate[cfg_voice]   <= cfg_gate;
            if (cfg_gate && !gate[cfg_voice]) begin
               phase[cfg_voice] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         idx          <= '0;
         acc          <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (state == MIX && sample_tick) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (sample_tick) begin
                  acc   <= '0;
                  idx   <= '0;
                  state <= MIX;
               end
            end
            MIX: begin
               if (idx == LAST_IDX) begin
                  sample_out   <= sat_val;
                  sample_valid <= 1'b1;
                  state        <= IDLE;
               end else begin
                  acc <= sum;
                  idx <= idx + IDX_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_wave_generator.sv
// Self-checking bench: sample-slot reference model compared every cycle, plus literal pins.
module tb_poly_wave_generator;

   localparam int NUM_VOICES = 4;
   localparam int PHASE_W    = 24;
   localparam int VOL_W      = 7;
   localparam int OUT_W      = 24;

   logic                     clk = 1'b0;
   logic                     reset_n = 1'b1;
   logic                     sample_tick = 1'b0;
   logic                     cfg_valid = 1'b0;
   logic [1:0]               cfg_voice = '0;
   logic [PHASE_W-1:0]       cfg_incr = '0;
   logic [VOL_W-1:0]         cfg_volume = '0;
   logic [1:0]               cfg_wave = '0;
   logic                     cfg_gate = 1'b0;
   logic                     ovr_clr = 1'b0;
   logic signed [OUT_W-1:0]  sample_out;
   logic                     sample_valid;
   logic                     overrun;

   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   poly_wave_generator #(
      .NUM_VOICES (NUM_VOICES),
      .PHASE_W    (PHASE_W),
      .VOL_W      (VOL_W),
      .OUT_W      (OUT_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_tick  (sample_tick),
      .cfg_valid    (cfg_valid),
      .cfg_voice    (cfg_voice),
      .cfg_incr     (cfg_incr),
      .cfg_volume   (cfg_volume),
      .cfg_wave     (cfg_wave),
      .cfg_gate     (cfg_gate),
      .ovr_clr      (ovr_clr),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   function automatic void check_output(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
      end
   endfunction

   // Reference model: voice k of a sample is evaluated at the k-th edge after the tick edge.
   longint m_incr  [NUM_VOICES];
   longint m_vol   [NUM_VOICES];
   longint m_phase [NUM_VOICES];
   int     m_wave  [NUM_VOICES];
   bit     m_gate  [NUM_VOICES];
   int     m_slot  = -1;
   longint m_acc   = 0;
   longint exp_out = 0;
   bit     exp_valid = 1'b0;
   bit     exp_ovr   = 1'b0;

   function automatic longint wave_of(input longint ph, input int w);
      longint p;
      longint t;
      p = ph >> (PHASE_W - 16);
      case (w)
         0: return (p >= 32768) ? -32768 : 32767;
         1: return p - 32768;
         2: begin
            t = (p >= 32768) ? 65535 - p : p;
            return 2 * t - 32768;
         end
         default: return 0;
      endcase
   endfunction

   function automatic longint sat(input longint s);
      longint hi;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      if (s > hi) return hi;
      if (s < -hi - 1) return -hi - 1;
      return s;
   endfunction

   always @(posedge clk or negedge reset_n) begin : model
      bit busy;
      int v;
      if (!reset_n) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            m_incr[i] = 0; m_vol[i] = 0; m_phase[i] = 0; m_wave[i] = 0; m_gate[i] = 0;
         end
         m_slot = -1; m_acc = 0; exp_out = 0; exp_valid = 0; exp_ovr = 0;
      end else begin
         busy = (m_slot >= 0);
         exp_valid = 0;
         if (busy) begin
            v = m_slot;
            if (m_gate[v]) begin
               m_acc += wave_of(m_phase[v], m_wave[v]) * m_vol[v];
               m_phase[v] = (m_phase[v] + m_incr[v]) % (longint'(1) << PHASE_W);
            end else begin
               m_phase[v] = 0;
            end
            if (v == NUM_VOICES - 1) begin
               exp_out = sat(m_acc);
               exp_valid = 1;
               m_slot = -1;
            end else begin
               m_slot++;
            end
         end else if (sample_tick) begin
            m_slot = 0;
            m_acc = 0;
         end
         if (busy && sample_tick) exp_ovr = 1;
         else if (ovr_clr) exp_ovr = 0;
         if (cfg_valid && int'(cfg_voice) < NUM_VOICES) begin
            v = int'(cfg_voice);
            if (cfg_gate && !m_gate[v]) m_phase[v] = 0;
            m_incr[v] = longint'(cfg_incr);
            m_vol[v]  = longint'(cfg_volume);
            m_wave[v] = int'(cfg_wave);
            m_gate[v] = cfg_gate;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check_output("sample_out", longint'(sample_out), exp_out);
         check_output("sample_valid", longint'(sample_valid), longint'(exp_valid));
         check_output("overrun", longint'(overrun), longint'(exp_ovr));
      end
   end

   task automatic cfg_write(input int v, input longint incr, input int vol, input int w, input bit g);
      @(posedge clk); #1;
      cfg_valid  = 1'b1;
      cfg_voice  = 2'(v);
      cfg_incr   = PHASE_W'(incr);
      cfg_volume = VOL_W'(vol);
      cfg_wave   = 2'(w);
      cfg_gate   = g;
      @(posedge clk); #1;
      cfg_valid  = 1'b0;
   endtask

   task automatic all_off();
      for (int v = 0; v < NUM_VOICES; v++) cfg_write(v, 0, 0, 3, 1'b0);
   endtask

   task automatic wait_valid(output longint s, output int lat);
      s = 0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (sample_valid) begin
            s = longint'(sample_out);
            lat = k;
            break;
         end
      end
      if (lat < 0) check_output("valid_timeout", 0, 1);
   endtask

   task automatic do_tick(output longint s, output int lat);
      @(posedge clk); #1;
      sample_tick = 1'b1;
      @(posedge clk); #1;
      sample_tick = 1'b0;
      wait_valid(s, lat);
   endtask

   task automatic apply_stimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         sample_tick = ($urandom_range(0, 5) == 0);
         ovr_clr     = ($urandom_range(0, 9) == 0);
         cfg_valid   = ($urandom_range(0, 3) == 0);
         cfg_voice   = 2'($urandom_range(0, 3));
         cfg_incr    = PHASE_W'($urandom);
         cfg_volume  = VOL_W'($urandom);
         cfg_wave    = 2'($urandom_range(0, 3));
         cfg_gate    = ($urandom_range(0, 3) != 0);
         if (i == cycles / 2) reset_n = 1'b0;
         if (i == cycles / 2 + 2) reset_n = 1'b1;
      end
      @(posedge clk); #1;
      sample_tick = 1'b0;
      ovr_clr     = 1'b0;
      cfg_valid   = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      longint s [1:17];
      longint smp;
      int     lat;
      int     nval;

      #2 reset_n = 1'b0;
      cmp_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (6) @(negedge clk);
      check_output("reset_sample_out", longint'(sample_out), 0);
      check_output("reset_valid", longint'(sample_valid), 0);
      check_output("reset_overrun", longint'(overrun), 0);

      // Saw on voice 0
      all_off();
      cfg_write(0, 64'h100000, 1, 1, 1'b1);
      for (int i = 1; i <= 17; i++) begin
         do_tick(s[i], lat);
         if (i == 1) check_output("saw_latency", lat, 5);
      end
      check_output("saw_s1", s[1], -32768);
      check_output("saw_s2", s[2], -28672);
      check_output("saw_s3", s[3], -24576);
      check_output("saw_s16", s[16], 28672);
      check_output("saw_wrap", s[17], -32768);

      // Triangle on voice 2
      all_off();
      cfg_write(2, 64'h400000, 1, 2, 1'b1);
      for (int i = 1; i <= 5; i++) do_tick(s[i], lat);
      check_output("tri_s1", s[1], -32768);
      check_output("tri_s2", s[2], 0);
      check_output("tri_s3", s[3], 32766);
      check_output("tri_s4", s[4], -2);
      check_output("tri_repeat", s[5], -32768);

      // Square saturation, all voices
      all_off();
      for (int v = 0; v < NUM_VOICES; v++) cfg_write(v, 64'h200000, 127, 0, 1'b1);
      for (int i = 1; i <= 5; i++) do_tick(s[i], lat);
      check_output("sq_sat_hi", s[1], 8388607);
      check_output("sq_sat_hi4", s[4], 8388607);
      check_output("sq_sat_lo", s[5], -8388608);

      // Overrun: second tick two cycles after the first
      all_off();
      @(posedge clk); #1 sample_tick = 1'b1;
      @(posedge clk); #1 sample_tick = 1'b0;
      @(posedge clk); #1 sample_tick = 1'b1;
      @(posedge clk); #1 sample_tick = 1'b0;
      nval = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (sample_valid) nval++;
      end
      check_output("ovr_one_valid", nval, 1);
      check_output("ovr_set", longint'(overrun), 1);
      @(posedge clk); #1 ovr_clr = 1'b1;
      @(posedge clk); #1 ovr_clr = 1'b0;
      @(negedge clk);
      check_output("ovr_cleared", longint'(overrun), 0);
      // Set and clear in the same cycle: set wins
      @(posedge clk); #1 sample_tick = 1'b1;
      @(posedge clk); #1 sample_tick = 1'b0;
      @(posedge clk); #1 begin sample_tick = 1'b1; ovr_clr = 1'b1; end
      @(posedge clk); #1 begin sample_tick = 1'b0; ovr_clr = 1'b0; end
      repeat (8) @(negedge clk);
      check_output("ovr_set_wins", longint'(overrun), 1);
      @(posedge clk); #1 ovr_clr = 1'b1;
      @(posedge clk); #1 ovr_clr = 1'b0;

      // Config write racing voice 1's MIX slot
      all_off();
      cfg_write(1, 0, 10, 0, 1'b1);
      @(posedge clk); #1 sample_tick = 1'b1;
      @(posedge clk); #1 sample_tick = 1'b0;
      @(posedge clk); #1;
      cfg_valid = 1'b1; cfg_voice = 2'd1; cfg_incr = '0; cfg_volume = VOL_W'(20);
      cfg_wave = 2'd0; cfg_gate = 1'b1;
      @(posedge clk); #1 cfg_valid = 1'b0;
      wait_valid(smp, lat);
      check_output("race_old_vol", smp, 327670);
      do_tick(smp, lat);
      check_output("race_new_vol", smp, 655340);

      // Reset in the second MIX cycle
      all_off();
      cfg_write(0, 64'h100000, 1, 1, 1'b1);
      do_tick(smp, lat);
      do_tick(smp, lat);
      @(posedge clk); #1 sample_tick = 1'b1;
      @(posedge clk); #1 sample_tick = 1'b0;
      @(posedge clk); #1 reset_n = 1'b0;
      nval = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (sample_valid) nval++;
      end
      check_output("midreset_no_valid", nval, 0);
      check_output("midreset_out", longint'(sample_out), 0);
      @(posedge clk); #1 reset_n = 1'b1;
      cfg_write(0, 64'h100000, 1, 1, 1'b1);
      cfg_write(2, 64'h400000, 1, 2, 1'b1);
      do_tick(smp, lat);
      check_output("midreset_restart", smp, -65536);

      // Randomized traffic against the model
      apply_stimulus(400);
      repeat (10) @(posedge clk);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
